// File: rtl/apb4_register_slave.sv
// APB4 slave exposing NUM_REGS word registers: reg0 counts committed writes, the rest are byte-strobed R/W.
// Every transfer inserts WAIT_STATES PREADY-low access cycles before completing.
module apb4_register_slave #(
    parameter int PADDR_SIZE  = 16,
    parameter int PDATA_SIZE  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);
    localparam int                    IDX_W     = $clog2(NUM_REGS);
    localparam int                    STRB_W    = PDATA_SIZE / 8;
    localparam logic [PADDR_SIZE-1:0] MAP_LIMIT = PADDR_SIZE'(NUM_REGS * 4);
    localparam logic [3:0]            WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [3:0]            wcnt, wcnt_nxt;
    logic [PDATA_SIZE-1:0] regs [NUM_REGS];
    logic [IDX_W-1:0]      idx;
    logic                  setup, access, addr_err, wr_commit;

    assign setup  = PSEL & ~PENABLE;
    assign access = PSEL & PENABLE;
    assign idx    = PADDR[IDX_W+1:2];

    // reg0 is read-only, so a write to it is reported like a bad address
    assign addr_err = (PADDR >= MAP_LIMIT) || (PADDR[1:0] != 2'b00) || (PWRITE && (idx == '0));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= S_IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            S_IDLE: begin
                if (setup) begin
                    wcnt_nxt  = WAIT_INIT;
                    state_nxt = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_nxt = S_IDLE;
                end else if (PENABLE) begin
                    wcnt_nxt = wcnt - 4'd1;
                    if (wcnt <= 4'd1) state_nxt = S_DONE;
                end
            end
            // DONE lasts one cycle whether it completed or the master walked away
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign PREADY    = access && (state == S_DONE);
    assign PSLVERR   = PREADY & addr_err;
    assign wr_commit = PREADY & PWRITE & ~addr_err;
    assign PRDATA    = (PREADY && !PWRITE && !addr_err) ? regs[idx] : '0;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_commit) begin
            regs[0] <= regs[0] + PDATA_SIZE'(1);
            // idx is never 0 here, so byte updates cannot collide with the counter
            for (int b = 0; b < STRB_W; b++) begin
                if (PSTRB[b]) regs[idx][b*8 +: 8] <= PWDATA[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_apb4_register_slave.sv
// Directed bench: three slaves (1 wait state, 0 wait states, 8-bit data) share one APB bus, each with its own PSEL.
module tb_apb4_register_slave;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  psel, pready, pslverr;
    logic [31:0] prd0, prd1;
    logic [7:0]  prd2;
    int          errors = 0;
    int          checks = 0;

    always #5 PCLK = ~PCLK;

    apb4_register_slave #(.PADDR_SIZE(16), .PDATA_SIZE(32), .NUM_REGS(8), .WAIT_STATES(1)) dut_w1 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PSTRB(pstrb), .PWDATA(pwdata), .PRDATA(prd0), .PREADY(pready[0]),
        .PSLVERR(pslverr[0]));

    apb4_register_slave #(.PADDR_SIZE(16), .PDATA_SIZE(32), .NUM_REGS(8), .WAIT_STATES(0)) dut_w0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PSTRB(pstrb), .PWDATA(pwdata), .PRDATA(prd1), .PREADY(pready[1]),
        .PSLVERR(pslverr[1]));

    apb4_register_slave #(.PADDR_SIZE(16), .PDATA_SIZE(8), .NUM_REGS(8), .WAIT_STATES(1)) dut_b8 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PSTRB(pstrb[0:0]), .PWDATA(pwdata[7:0]), .PRDATA(prd2), .PREADY(pready[2]),
        .PSLVERR(pslverr[2]));

    // Called #1 after a rising edge; returns #1 after the completion edge with PSEL low,
    // so two consecutive calls form a back-to-back pair.
    task automatic xfer(input int which, input logic wr, input logic [15:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic err, output int waits);
        logic done;
        done  = 1'b0;
        waits = 0;
        rdata = '0;
        err   = 1'b0;
        psel = '0; psel[which] = 1'b1; penable = 1'b0;
        paddr = addr; pwrite = wr; pwdata = data; pstrb = strb;
        @(posedge PCLK); #1;
        penable = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge PCLK);
            if (pready[which]) begin
                done = 1'b1;
                err  = pslverr[which];
                case (which)
                    0:       rdata = prd0;
                    1:       rdata = prd1;
                    default: rdata = {24'h0, prd2};
                endcase
            end else begin
                waits++;
            end
            @(posedge PCLK); #1;
        end
        psel = '0; penable = 1'b0;
        checks++;
        if (!done) begin errors++; $display("FAIL xfer_timeout which=%0d addr=%h no PREADY in 20 cycles", which, addr); end
    endtask

    task automatic idle_cycle();
        @(posedge PCLK); #1;
    endtask

    task automatic test_reset();
        PRESET = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        #12;
        checks++; if (pready !== 3'b000) begin errors++; $display("FAIL reset_pready got=%b exp=000", pready); end
        checks++; if (pslverr !== 3'b000) begin errors++; $display("FAIL reset_pslverr got=%b exp=000", pslverr); end
        checks++; if (prd0 !== 32'h0 || prd1 !== 32'h0 || prd2 !== 8'h0) begin
            errors++; $display("FAIL reset_prdata got=%h/%h/%h exp=0", prd0, prd1, prd2); end
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        idle_cycle();
    endtask

    task automatic test_read_reg3();
        logic [31:0] rd; logic er; int w;
        xfer(0, 1'b0, 16'h000C, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reg3_rdata got=%h exp=%h", rd, 32'h0); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL reg3_slverr got=%b exp=0", er); end
        checks++; if (w != 1) begin errors++; $display("FAIL reg3_waits got=%0d exp=1", w); end
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic er; int w;
        xfer(0, 1'b1, 16'h0004, 32'h11223344, 4'h5, rd, er, w);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL strb_wr_slverr got=%b exp=0", er); end
        checks++; if (w != 1) begin errors++; $display("FAIL strb_wr_waits got=%0d exp=1", w); end
        xfer(0, 1'b0, 16'h0004, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h00220044) begin errors++; $display("FAIL strb_rd_reg1 got=%h exp=%h", rd, 32'h00220044); end
        xfer(0, 1'b0, 16'h0000, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h00000001) begin errors++; $display("FAIL strb_rd_reg0 got=%h exp=%h", rd, 32'h1); end
        // zero strobes: completes cleanly, data untouched, counter still advances
        xfer(0, 1'b1, 16'h0004, 32'hFFFFFFFF, 4'h0, rd, er, w);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL zstrb_slverr got=%b exp=0", er); end
        xfer(0, 1'b0, 16'h0004, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h00220044) begin errors++; $display("FAIL zstrb_reg1 got=%h exp=%h", rd, 32'h00220044); end
        xfer(0, 1'b0, 16'h0000, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h00000002) begin errors++; $display("FAIL zstrb_reg0 got=%h exp=%h", rd, 32'h2); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int w;
        xfer(0, 1'b1, 16'h0000, 32'h12345678, 4'hF, rd, er, w);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_wr_reg0 slverr got=%b exp=1", er); end
        xfer(0, 1'b1, 16'h0020, 32'h12345678, 4'hF, rd, er, w);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_wr_range slverr got=%b exp=1", er); end
        xfer(0, 1'b0, 16'h0006, 32'h0, 4'h0, rd, er, w);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_rd_unaligned slverr got=%b exp=1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_rd_prdata got=%h exp=0", rd); end
        #2;
        checks++; if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0) begin
            errors++; $display("FAIL err_idle_outputs pready=%b pslverr=%b exp=0/0", pready[0], pslverr[0]); end
        xfer(0, 1'b0, 16'h0000, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h00000002 || er !== 1'b0) begin
            errors++; $display("FAIL err_reg0_unchanged got=%h slverr=%b exp=%h/0", rd, er, 32'h2); end
    endtask

    task automatic test_psel_drop();
        logic [31:0] rd; logic er; int w;
        psel = 3'b001; penable = 1'b0; paddr = 16'h0010; pwrite = 1'b1;
        pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        checks++; if (pready[0] !== 1'b0) begin errors++; $display("FAIL drop_wait_pready got=%b exp=0", pready[0]); end
        @(posedge PCLK); #1;
        psel = '0; penable = 1'b0;
        @(negedge PCLK);
        checks++; if (pready[0] !== 1'b0) begin errors++; $display("FAIL drop_done_pready got=%b exp=0", pready[0]); end
        @(posedge PCLK); #1;
        xfer(0, 1'b0, 16'h0010, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL drop_reg4 got=%h exp=0", rd); end
        xfer(0, 1'b0, 16'h0000, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h00000002) begin errors++; $display("FAIL drop_reg0 got=%h exp=%h", rd, 32'h2); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int w;
        xfer(1, 1'b1, 16'h0008, 32'hA5A5A5A5, 4'hF, rd, er, w);
        checks++; if (w != 0 || er !== 1'b0) begin errors++; $display("FAIL b2b_w0_wr waits=%0d slverr=%b exp=0/0", w, er); end
        xfer(1, 1'b0, 16'h0008, 32'h0, 4'h0, rd, er, w);
        checks++; if (w != 0) begin errors++; $display("FAIL b2b_w0_rd_waits got=%0d exp=0", w); end
        checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_w0_rd got=%h exp=%h", rd, 32'hA5A5A5A5); end
        xfer(0, 1'b1, 16'h001C, 32'h0BADC0DE, 4'hF, rd, er, w);
        xfer(0, 1'b0, 16'h001C, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h0BADC0DE || w != 1) begin
            errors++; $display("FAIL b2b_w1_rd got=%h waits=%0d exp=%h/1", rd, w, 32'h0BADC0DE); end
        xfer(0, 1'b0, 16'h0000, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h00000003) begin errors++; $display("FAIL b2b_w1_reg0 got=%h exp=%h", rd, 32'h3); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int w;
        psel = 3'b001; penable = 1'b0; paddr = 16'h000C; pwrite = 1'b1;
        pwdata = 32'hDEADBEEF; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b1;
        #2;
        checks++; if (pready[0] !== 1'b0 || prd0 !== 32'h0) begin
            errors++; $display("FAIL rst_async pready=%b prdata=%h exp=0/0", pready[0], prd0); end
        @(posedge PCLK); #1;
        psel = '0; penable = 1'b0; PRESET = 1'b0;
        xfer(0, 1'b0, 16'h000C, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h0 || w != 1) begin errors++; $display("FAIL rst_abort_reg3 got=%h waits=%0d exp=0/1", rd, w); end
        xfer(0, 1'b0, 16'h0000, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_abort_reg0 got=%h exp=0", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er; int w; int bad;
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            xfer(2, 1'b1, 16'h0004, {24'h0, 8'(i)}, 4'h1, rd, er, w);
            if (er !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_writes slverr_count got=%0d exp=0", bad); end
        xfer(2, 1'b0, 16'h0000, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h000000FF) begin errors++; $display("FAIL wrap_pre got=%h exp=%h", rd, 32'hFF); end
        xfer(2, 1'b0, 16'h0004, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h000000FE) begin errors++; $display("FAIL wrap_reg1 got=%h exp=%h", rd, 32'hFE); end
        xfer(2, 1'b1, 16'h0008, 32'h0000005A, 4'h1, rd, er, w);
        xfer(2, 1'b0, 16'h0000, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wrap_reg0 got=%h exp=0", rd); end
        xfer(2, 1'b0, 16'h0008, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'h0000005A) begin errors++; $display("FAIL wrap_reg2 got=%h exp=%h", rd, 32'h5A); end
    endtask

    initial begin
        test_reset();
        test_read_reg3();
        test_strobe();
        test_errors();
        test_psel_drop();
        test_back_to_back();
        test_reset_abort();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb4_register_slave.md
APB4_REGISTER_SLAVE -- requirements
Module: apb4_register_slave

Interface
REQ-001 The block SHALL have parameter PADDR_SIZE, default 16, address width.
REQ-002 The block SHALL have parameter PDATA_SIZE, default 32, data width, multiple of 8.
REQ-003 The block SHALL have parameter NUM_REGS, default 8, number of word registers, power of two, at least 2.
REQ-004 The block SHALL have parameter WAIT_STATES, default 1, number of PREADY-low access cycles per transfer, 0..15.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset; ports are PCLK and PRESET.
REQ-006 The block SHALL have port PCLK, input, 1 bit, clock; all state updates on its rising edge.
REQ-007 The block SHALL have port PRESET, input, 1 bit, asynchronous active-high reset.
REQ-008 The block SHALL have port PSEL, input, 1 bit, slave select.
REQ-009 The block SHALL have port PENABLE, input, 1 bit, access phase indicator.
REQ-010 The block SHALL have port PADDR, input, PADDR_SIZE bits, byte address.
REQ-011 The block SHALL have port PWRITE, input, 1 bit, 1 = write and 0 = read.
REQ-012 The block SHALL have port PSTRB, input, PDATA_SIZE/8 bits, write byte enables.
REQ-013 The block SHALL have port PWDATA, input, PDATA_SIZE bits, write data.
REQ-014 The block SHALL have port PRDATA, output, PDATA_SIZE bits, read data.
REQ-015 The block SHALL have port PREADY, output, 1 bit, transfer completion.
REQ-016 The block SHALL have port PSLVERR, output, 1 bit, transfer error, valid only while PREADY=1.

Function
REQ-017 Register map SHALL be: index = PADDR[log2(NUM_REGS)+1:2]; reg0 read-only write counter; reg1..NUM_REGS-1 read/write.
REQ-018 An address SHALL be in error when PADDR >= NUM_REGS*4, or PADDR[1:0] != 0, or the transfer is a write to reg0.
REQ-019 The FSM SHALL have states IDLE, WAIT and DONE; IDLE->WAIT, or IDLE->DONE when WAIT_STATES=0, on a setup phase (PSEL=1, PENABLE=0).
REQ-020 On a setup phase the wait counter SHALL load WAIT_STATES; in WAIT it SHALL decrement each access cycle and go to DONE when it reaches 0.
REQ-021 PREADY SHALL be 1 exactly when PSEL=1, PENABLE=1 and state=DONE, giving WAIT_STATES access cycles with PREADY=0; PREADY SHALL be 0 otherwise.
REQ-022 DONE SHALL return to IDLE after the cycle with PREADY=1; back-to-back setup in that next cycle SHALL be accepted.
REQ-023 A write SHALL commit on the rising edge with PSEL&PENABLE&PREADY&PWRITE and no error; byte i updates only if PSTRB[i]=1.
REQ-024 reg0 SHALL increment by 1, wrapping modulo 2^PDATA_SIZE, on every committed write.
REQ-025 On a read with PREADY=1 and no error, PRDATA SHALL equal the addressed register; PRDATA SHALL be 0 in all other cycles.
REQ-026 PSLVERR SHALL be 1 only in a PREADY=1 cycle of an erroring transfer; erroring writes SHALL change no register and SHALL NOT increment reg0.
REQ-027 If PSEL drops in WAIT or DONE before completion, the FSM SHALL go to IDLE with no write and no counter change.
REQ-028 A PSTRB of all zeros on a valid write SHALL complete with PSLVERR=0, leave reg1..N-1 unchanged, and still increment reg0.

Reset
REQ-029 While PRESET=1 the block SHALL hold state=IDLE, wait counter=0, all registers=0, PREADY=0, PSLVERR=0 and PRDATA=0, independent of PCLK.
REQ-030 PRESET asserted during a transfer SHALL abort it with no commit; the first setup phase after release SHALL be served normally.

Verification
REQ-031 The bench SHALL check: reset, then read reg3 -> PRDATA=0x00000000, PSLVERR=0, PREADY low for exactly 1 access cycle.
REQ-032 The bench SHALL check: write 0x11223344 to 0x0004 with PSTRB=0x5, then read 0x0004 -> 0x00220044; read 0x0000 -> 0x00000001.
REQ-033 The bench SHALL check: write to 0x0000, then write to 0x0020 (NUM_REGS=8), then read 0x0006 -> each sees PSLVERR=1; reg0 unchanged.
REQ-034 The bench SHALL check: with WAIT_STATES=0, back-to-back write 0xA5A5A5A5 to 0x0008 then read 0x0008 -> PREADY=1 in the first access cycle and read returns 0xA5A5A5A5.
REQ-035 The bench SHALL check: write 0xDEADBEEF to 0x000C with PRESET pulsed during the wait cycle -> later read of 0x000C returns 0 and reg0 reads 0.
REQ-036 The bench SHALL check: preload reg0 to 0xFFFFFFFF via 2^32-1 writes in a fast-forward model, or use PDATA_SIZE=8 with 255 writes, then one more write -> reg0 wraps to 0.
